spi_responder: RTL

// - Synthesizable SPI target that answers an SoC SPI controller (sclk/ss/mosi/miso).
// - Oversamples the SPI pins on the system clock and serves a small byte-wide register file.
// - Provides WRITE, READ and ID commands.
// - Used in DH-006 benches and FPGA loopback builds as the far end of io_spi0.

---
 rtl/spi_responder_pkg.sv | 21 ++
 rtl/spi_pin_sync.sv | 50 +++++
 rtl/spi_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_responder_pkg.sv
// rtl/spi_responder_pkg.sv - shared FSM state type and command codes for spi_responder
// Purpose: one place for the state encoding and the SPI command bytes so the
//          top level and any sub-module agree on them.
// Ports:   none (package).
package spi_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WRDATA,
    RDDATA,
    ID,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_ID    = 8'h9F;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-flop synchronizer with rise/fall pulse outputs
// Purpose: brings one asynchronous SPI pin into the clk domain and flags its edges.
// Ports:
//   clk      in  1  system clock
//   resetn   in  1  synchronous, active-low reset
//   pin_in   in  1  asynchronous pin
//   sync_out out 1  synchronized level
//   rise     out 1  one-cycle pulse on a synchronized 0->1 transition
//   fall     out 1  one-cycle pulse on a synchronized 1->0 transition
module spi_pin_sync
  import spi_responder_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin_in};
    prev_d = sync_q[STAGES-1];
  end

  // Resetting every stage to 0 means a pin that is already low when reset
  // releases (e.g. ss mid-frame) produces no fall pulse, so a cut-off frame
  // cannot be mistaken for a new one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_q[STAGES-1] & ~prev_q;
  assign fall     = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - oversampling SPI target serving a byte-wide register file
// Purpose: decodes WRITE (02), READ (03) and ID (9F) frames from an SPI
//          controller and serves a DEPTH x 8 register file.
// Ports:
//   io_clock       in  1       system clock
//   io_resetn      in  1       synchronous, active-low reset
//   io_spi_sclk    in  1       SPI clock (asynchronous)
//   io_spi_ss      in  1       active-low target select
//   io_spi_mosi    in  1       controller -> target data, MSB first
//   io_spi_miso    out 1       target -> controller data, MSB first
//   io_writeStrobe out 1       one-cycle pulse per committed data byte
//   io_writeAddr   out ADDR_W  address of the committed byte
//   io_writeData   out 8       value of the committed byte
//   io_frameCount  out 16      completed frames containing at least one full byte
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         CPOL        = 0,
  parameter int         CPHA        = 0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  localparam int        ADDR_W      = $clog2(DEPTH)
) (
  input  logic              io_clock,
  input  logic              io_resetn,
  input  logic              io_spi_sclk,
  input  logic              io_spi_ss,
  input  logic              io_spi_mosi,
  output logic              io_spi_miso,
  output logic              io_writeStrobe,
  output logic [ADDR_W-1:0] io_writeAddr,
  output logic [7:0]        io_writeData,
  output logic [15:0]       io_frameCount
);

  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(io_clock), .resetn(io_resetn), .pin_in(io_spi_sclk),
    .sync_out(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(io_clock), .resetn(io_resetn), .pin_in(io_spi_ss),
    .sync_out(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(io_clock), .resetn(io_resetn), .pin_in(io_spi_mosi),
    .sync_out(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // sclk edges count while ss is low, and also on the cycle ss rises so a
  // byte completing together with the ss rise is still committed.
  logic sclk_ok, lead, trail, sample_edge, shift_edge;
  assign sclk_ok     = ~ss_s | ss_rise;
  assign lead        = sclk_ok & ((CPOL == 0) ? sclk_rise : sclk_fall);
  assign trail       = sclk_ok & ((CPOL == 0) ? sclk_fall : sclk_rise);
  assign sample_edge = (CPHA == 0) ? lead  : trail;
  assign shift_edge  = (CPHA == 0) ? trail : lead;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic                miso_hold_q, miso_hold_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_read_q, is_read_d;
  logic                got_byte_q, got_byte_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          mem_q [DEPTH];
  logic                mem_we;
  logic [7:0]          rx_byte;

  assign rx_byte = {rx_shift_q[6:0], mosi_s};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    miso_hold_d   = miso_hold_q;
    addr_d        = addr_q;
    is_read_d     = is_read_q;
    got_byte_d    = got_byte_q;
    frame_count_d = frame_count_q;
    wr_strobe_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    mem_we        = 1'b0;

    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d     = CMD;
        bit_cnt_d   = 3'd0;
        rx_shift_d  = 8'h00;
        tx_shift_d  = 8'h00;
        miso_hold_d = 1'b0;
        got_byte_d  = 1'b0;
      end
    end else begin
      if (shift_edge) begin
        if (CPHA == 0) begin
          // The trailing edge after the 8th sample must not shift: the next
          // byte's MSB was just loaded and has to stay on MISO for the next lead.
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end else begin
          // Leading edge presents the next bit; the hold flop keeps it stable
          // until the controller samples on the trailing edge.
          miso_hold_d = tx_shift_q[7];
          tx_shift_d  = {tx_shift_q[6:0], 1'b0};
        end
      end

      if (sample_edge) begin
        rx_shift_d = rx_byte;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          got_byte_d = 1'b1;
          case (state_q)
            CMD: begin
              tx_shift_d = 8'h00;
              if (rx_byte == CMD_WRITE) begin
                state_d   = ADDR;
                is_read_d = 1'b0;
              end else if (rx_byte == CMD_READ) begin
                state_d   = ADDR;
                is_read_d = 1'b1;
              end else if (rx_byte == CMD_ID) begin
                state_d    = ID;
                tx_shift_d = ID_VALUE;
              end else begin
                state_d = IGNORE;
              end
            end
            ADDR: begin
              if (is_read_q) begin
                tx_shift_d = mem_q[rx_byte[ADDR_W-1:0]];
                addr_d     = rx_byte[ADDR_W-1:0] + ADDR_INC;
                state_d    = RDDATA;
              end else begin
                tx_shift_d = 8'h00;
                addr_d     = rx_byte[ADDR_W-1:0];
                state_d    = WRDATA;
              end
            end
            WRDATA: begin
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = rx_byte;
              addr_d      = addr_q + ADDR_INC;
            end
            RDDATA: begin
              tx_shift_d = mem_q[addr_q];
              addr_d     = addr_q + ADDR_INC;
            end
            ID: begin
              tx_shift_d = ID_VALUE;
            end
            default: begin
              tx_shift_d = 8'h00;
            end
          endcase
        end
      end

      if (ss_rise) begin
        state_d = IDLE;
        if (got_byte_d) begin
          frame_count_d = frame_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      miso_hold_q   <= 1'b0;
      addr_q        <= '0;
      is_read_q     <= 1'b0;
      got_byte_q    <= 1'b0;
      frame_count_q <= 16'd0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      miso_hold_q   <= miso_hold_d;
      addr_q        <= addr_d;
      is_read_q     <= is_read_d;
      got_byte_q    <= got_byte_d;
      frame_count_q <= frame_count_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      if (mem_we) begin
        mem_q[addr_q] <= rx_byte;
      end
    end
  end

  assign io_spi_miso    = (state_q != IDLE) & ~ss_s &
                          ((CPHA == 0) ? tx_shift_q[7] : miso_hold_q);
  assign io_writeStrobe = wr_strobe_q;
  assign io_writeAddr   = wr_addr_q;
  assign io_writeData   = wr_data_q;
  assign io_frameCount  = frame_count_q;

endmodule
